ds1302_ctrlmod: RTL and testbench
=================================

# ds1302_ctrlmod

Sequencer that sits above `ds1302_funcmod` and owns the DS1302 time-keeping protocol. After reset it clears write-protect, restarts the oscillator if the Clock-Halt bit is set, and re-enables write-protect. It then polls seconds, minutes and hours every `POLL_CYCLES` and publishes them as one coherent BCD snapshot. It also accepts a user "set time" request and turns it into the required burst of single-byte writes. It is the only master of the function module's call interface.

## Interface
Parameters:
- `POLL_CYCLES`, default 5_000_000: CLOCK cycles between poll starts; 100 ms at 50 MHz.
- `TIMEOUT`, default 1023: maximum cycles to wait for `iFuncDone` per transaction.

Ports:
- `CLOCK`  in  1  system clock, 50 MHz.
- `RST`  in  1  asynchronous, active-high reset.
- `iSet`  in  1  set-time request level; must be held until `oSetDone`.
- `iTime`  in  24  {hour, min, sec}, BCD; sampled on the cycle the set is accepted.
- `oSetDone`  out  1  one-cycle pulse when the set sequence finishes.
- `oSec`, `oMin`, `oHour`  out  8 each  last published BCD time.
- `oTick`  out  1  one-cycle pulse when `oSec`/`oMin`/`oHour` update.
- `oReady`  out  1  high once init is complete.
- `oErr`  out  1  sticky timeout flag.
- `oFuncCall`  out  2  to function module: 2'b10 = write, 2'b01 = read, 2'b00 = idle.
- `oFuncAddr`, `oFuncData`  out  8 each  address and write data to the function module.
- `iFuncDone`  in  1  done pulse from the function module.
- `iFuncData`  in  8  read result from the function module.

## Operation
Transaction primitive, used for every access:
- **ISSUE:** drive `oFuncCall`, `oFuncAddr` and `oFuncData` stable. Count wait cycles.
- On the `iFuncDone` cycle, capture `iFuncData`; the call drops to 00 at the next edge.
- **GAP:** exactly one cycle with call 00, then move to the next step. This prevents the function module from re-running the same command.
- If the wait count reaches `TIMEOUT`, set `oErr`, drop the call, and take one GAP cycle. From IDLE, POLL or SET steps, go to IDLE. During INIT, continue to the next INIT step so the block still reaches IDLE.

Steps, in sequence:
- **INIT:**
  - Write 0x8E←0x00.
  - Read 0x81 → S.
  - If S[7]=1, write 0x80←{1'b0, S[6:0]}; otherwise skip this write.
  - Write 0x8E←0x80.
  - Assert `oReady`, go to IDLE.
- **IDLE:**
  - If `iSet` is high, latch `iTime` and go to SET. Set has priority over poll when both are pending.
  - Else if the poll request is pending, go to POLL.
- **POLL:**
  - Read 0x81 → s, 0x83 → m, 0x85 → h into shadow registers.
  - PUBLISH: in one cycle, `oSec`←{0, s[6:0]}, `oMin`←{0, m[6:0]}, `oHour`←{00, h[5:0]}, pulse `oTick`.
  - Return to IDLE.
- **SET:**
  - Write 0x8E←0x00.
  - Write 0x80←{0, sec[6:0]} (clears CH).
  - Write 0x82←{0, min[6:0]}.
  - Write 0x84←{00, hour[5:0]} (forces 24-h mode).
  - Write 0x8E←0x80.
  - Pulse `oSetDone`, set the poll request pending so a poll follows immediately, then return to IDLE.
- `iSet` arriving during INIT or POLL waits; it is accepted at the next IDLE cycle.

Poll timer:
- Free-running counter, 0 to `POLL_CYCLES`-1.
- On wrap, set the poll request pending. The pending flag clears when POLL is entered.
- A wrap during POLL or SET is not lost, but multiple wraps coalesce into one request.

## Timing
- Reset values: all outputs 0, `oFuncCall`=00, internal state at INIT step 0. INIT starts on the first edge after `RST` deasserts.
- `RST` asserted mid-transaction forces call 00 immediately; the function module is reset by the same system reset.
- Per access: call asserted → `iFuncDone` is about 2×8×25+5 cycles for a write, similar for a read, then 1 GAP cycle.
- Set accept: `iTime` is latched on the IDLE cycle where `iSet`=1. `oSetDone` comes 5 transactions later.
- `oTick` and the output update happen on the same edge; outputs stay stable between ticks.
- `oFuncAddr`/`oFuncData` change only while the call is 00.

## Test plan
- **Reset/init, CH=0:** model returns 0x81→0x25. Expect writes 8E←00, read 81, write 8E←80 (no 80 write); `oReady`=1.
- **Init, CH set:** model returns 0x81→0xA5. Expect write 80←0x25 between the read and 8E←80.
- **Poll:** `POLL_CYCLES`=2000, model returns s=0x59, m=0x07, h=0x23. Expect reads 81, 83, 85, then `oTick` with oSec=0x59, oMin=0x07, oHour=0x23. Next tick ≈2000 cycles after the previous poll start.
- **Set:** `iSet` with `iTime`=24'h12_34_D6. Expect writes 8E←00, 80←56, 82←34, 84←12, 8E←80; `oSetDone`; an immediate poll follows.
- **Set during poll:** raise `iSet` mid-POLL. The poll completes with `oTick` first, then the set sequence runs; no call overlaps, and there is a GAP cycle between every pair of calls.
- **Timeout:** model never asserts done. After `TIMEOUT` cycles, `oErr`=1, call 00, and the block returns to IDLE; `oErr` stays high through later successful polls.

Source files
------------

// File: rtl/ds1302_ctrlmod_if.sv
// ds1302_ctrlmod_if: user-side and function-module-side signals of the DS1302 sequencer.
interface ds1302_ctrlmod_if;
   logic        iSet;
   logic [23:0] iTime;
   logic        oSetDone;
   logic [7:0]  oSec, oMin, oHour;
   logic        oTick, oReady, oErr;
   logic [1:0]  oFuncCall;
   logic [7:0]  oFuncAddr, oFuncData;
   logic        iFuncDone;
   logic [7:0]  iFuncData;
   modport master (
      input  iSet, iTime, iFuncDone, iFuncData,
      output oSetDone, oSec, oMin, oHour, oTick, oReady, oErr, oFuncCall, oFuncAddr, oFuncData
   );
   modport slave (
      output iSet, iTime, iFuncDone, iFuncData,
      input  oSetDone, oSec, oMin, oHour, oTick, oReady, oErr, oFuncCall, oFuncAddr, oFuncData
   );
endinterface

// File: rtl/ds1302_ctrlmod.sv
// ds1302_ctrlmod: DS1302 init / periodic poll / set-time sequencer, sole master of the function module.
module ds1302_ctrlmod #(
   parameter int POLL_CYCLES = 5_000_000,
   parameter int TIMEOUT     = 1023
) (
   input logic CLOCK,
   input logic RST,
   ds1302_ctrlmod_if.master bus
);
   localparam int PW = $clog2(POLL_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [3:0] {
      INIT_WR0, INIT_RD, INIT_CH, INIT_WP, IDLE, POLL_S, POLL_M, POLL_H, PUB,
      SET_WP0, SET_S, SET_M, SET_H, SET_WP1
   } step_t;
   typedef enum logic [1:0] {PH_BOOT, PH_ISSUE, PH_WAIT} ph_t;
   step_t step_q, step_d;
   ph_t ph_q, ph_d;
   logic [TW-1:0] wait_q, wait_d;
   logic [PW-1:0] tmr_q, tmr_d;
   logic pend_q, pend_d, tick_q, tick_d, ready_q, ready_d, err_q, err_d, done_q, done_d;
   logic [23:0] time_q, time_d;
   logic [7:0] s_q, s_d, m_q, m_d, h_q, h_d, sec_q, sec_d, min_q, min_d, hour_q, hour_d;
   logic [7:0] addr_q, addr_d, data_q, data_d;
   logic [1:0] call_q, call_d;
   logic wrap, init, rd, to;
   function automatic step_t next_step(input step_t s, input logic ch);
      case (s)
         INIT_WR0: return INIT_RD;
         INIT_RD:  return ch ? INIT_CH : INIT_WP;
         INIT_CH:  return INIT_WP;
         POLL_S:   return POLL_M;
         POLL_M:   return POLL_H;
         POLL_H:   return PUB;
         SET_WP0:  return SET_S;
         SET_S:    return SET_M;
         SET_M:    return SET_H;
         SET_H:    return SET_WP1;
         default:  return IDLE;
      endcase
   endfunction
   function automatic logic [7:0] addr_of(input step_t s);
      case (s)
         INIT_RD, POLL_S:  return 8'h81;
         INIT_CH, SET_S:   return 8'h80;
         POLL_M:           return 8'h83;
         POLL_H:           return 8'h85;
         SET_M:            return 8'h82;
         SET_H:            return 8'h84;
         IDLE, PUB:        return 8'h00;
         default:          return 8'h8E;
      endcase
   endfunction
   function automatic logic [7:0] data_of(input step_t s, input logic [7:0] rd_val, input logic [23:0] t);
      case (s)
         INIT_CH:          return {1'b0, rd_val[6:0]};
         INIT_WP, SET_WP1: return 8'h80;
         SET_S:            return {1'b0, t[6:0]};
         SET_M:            return {1'b0, t[14:8]};
         SET_H:            return {2'b00, t[21:16]};
         default:          return 8'h00;
      endcase
   endfunction
   always_comb begin
      step_d = step_q;
      ph_d = ph_q;
      wait_d = wait_q;
      time_d = time_q;
      s_d = s_q;
      m_d = m_q;
      h_d = h_q;
      sec_d = sec_q;
      min_d = min_q;
      hour_d = hour_q;
      call_d = call_q;
      addr_d = addr_q;
      data_d = data_q;
      ready_d = ready_q;
      err_d = err_q;
      tick_d = 1'b0;
      done_d = 1'b0;
      init = step_q inside {INIT_WR0, INIT_RD, INIT_CH, INIT_WP};
      rd = step_q inside {INIT_RD, POLL_S, POLL_M, POLL_H};
      wrap = tmr_q == PW'(POLL_CYCLES - 1);
      to = !bus.iFuncDone && wait_q == TW'(TIMEOUT - 1);
      tmr_d = wrap ? '0 : tmr_q + PW'(1);
      pend_d = pend_q | wrap;
      if (step_q == IDLE) begin
         if (bus.iSet) begin
            step_d = SET_WP0;
            time_d = bus.iTime;
            ph_d = PH_ISSUE;
         end else if (pend_q) begin
            step_d = POLL_S;
            pend_d = wrap;
            ph_d = PH_ISSUE;
         end
      end else if (step_q == PUB) begin
         sec_d = {1'b0, s_q[6:0]};
         min_d = {1'b0, m_q[6:0]};
         hour_d = {2'b00, h_q[5:0]};
         tick_d = 1'b1;
         step_d = IDLE;
      end else if (ph_q != PH_WAIT) begin
         // The ISSUE cycle doubles as the mandatory one-cycle gap with call 00
         ph_d = ph_q == PH_BOOT ? PH_ISSUE : PH_WAIT;
         call_d = ph_q == PH_BOOT ? 2'b00 : (rd ? 2'b01 : 2'b10);
         wait_d = '0;
      end else if (bus.iFuncDone || to) begin
         call_d = 2'b00;
         ph_d = PH_ISSUE;
         err_d = err_q | to;
         s_d = step_q == POLL_S ? bus.iFuncData : s_q;
         m_d = step_q == POLL_M ? bus.iFuncData : m_q;
         h_d = step_q == POLL_H ? bus.iFuncData : h_q;
         step_d = to && !init ? IDLE : next_step(step_q, !to && bus.iFuncData[7]);
         ready_d = ready_q | step_q == INIT_WP;
         done_d = step_q == SET_WP1 && !to;
         pend_d = pend_d | done_d;
      end else
         wait_d = wait_q + TW'(1);
      // Address/data move only when a step is entered, i.e. while the call is 00
      if (ph_q == PH_BOOT || step_d != step_q) begin
         addr_d = addr_of(step_d);
         data_d = data_of(step_d, bus.iFuncData, time_d);
      end
   end
   always_ff @(posedge CLOCK or posedge RST) begin
      if (RST) begin
         step_q <= INIT_WR0;
         ph_q <= PH_BOOT;
         wait_q <= '0;
         tmr_q <= '0;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         ready_q <= 1'b0;
         err_q <= 1'b0;
         done_q <= 1'b0;
         time_q <= '0;
         s_q <= '0;
         m_q <= '0;
         h_q <= '0;
         sec_q <= '0;
         min_q <= '0;
         hour_q <= '0;
         call_q <= 2'b00;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         step_q <= step_d;
         ph_q <= ph_d;
         wait_q <= wait_d;
         tmr_q <= tmr_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         ready_q <= ready_d;
         err_q <= err_d;
         done_q <= done_d;
         time_q <= time_d;
         s_q <= s_d;
         m_q <= m_d;
         h_q <= h_d;
         sec_q <= sec_d;
         min_q <= min_d;
         hour_q <= hour_d;
         call_q <= call_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end
   assign bus.oFuncCall = call_q;
   assign bus.oFuncAddr = addr_q;
   assign bus.oFuncData = data_q;
   assign bus.oSec = sec_q;
   assign bus.oMin = min_q;
   assign bus.oHour = hour_q;
   assign bus.oTick = tick_q;
   assign bus.oReady = ready_q;
   assign bus.oErr = err_q;
   assign bus.oSetDone = done_q;
endmodule

// File: tb/tb_ds1302_ctrlmod.sv
// tb_ds1302_ctrlmod: scoreboard bench with a behavioural DS1302 function-module model.
module tb_ds1302_ctrlmod;
   localparam int TO = 60;
   localparam int LAT = 20;
   typedef struct {
      logic       tk;
      logic [1:0] call;
      logic [7:0] a, d, h;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hang = 1'b0;
   int n_cmp = 0, n_bad = 0, cyc = 0, rise_cyc = 0, t1;
   logic [7:0] rtc [8];
   exp_t q[$];
   exp_t e;
   logic [1:0] pc = 2'b00;
   logic [7:0] ra = 8'h00, pa = 8'h00;
   ds1302_ctrlmod_if bus();
   ds1302_ctrlmod #(.POLL_CYCLES(2000), .TIMEOUT(TO)) dut (.CLOCK(clk), .RST(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic tx(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
      q.push_back('{1'b0, c, a, d, 8'h00});
   endtask
   task automatic poll(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
      tx(2'b01, 8'h81, 8'h00);
      tx(2'b01, 8'h83, 8'h00);
      tx(2'b01, 8'h85, 8'h00);
      q.push_back('{1'b1, 2'b00, s, m, h});
   endtask
   function automatic logic ev(input int sel);
      case (sel)
         0: return bus.oReady;
         1: return bus.oTick;
         2: return bus.oSetDone;
         3: return bus.oErr;
         4: return bus.oFuncCall == 2'b01 && bus.oFuncAddr == 8'h83;
         default: return bus.oFuncCall != 2'b00;
      endcase
   endfunction
   task automatic wait_ev(input int sel, input int maxc, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ev(sel) && n < maxc);
      chk(nm, 32'(ev(sel)), 1);
   endtask
   task automatic chk_reset(input string nm);
      chk({nm, "_time"}, {bus.oSec, bus.oMin, bus.oHour}, 0);
      chk({nm, "_ctl"}, {bus.oSetDone, bus.oTick, bus.oReady, bus.oErr, bus.oFuncCall, bus.oFuncAddr, bus.oFuncData}, 0);
   endtask
   // Function-module model: answers each call LAT cycles after it appears, unless hung
   initial begin
      int cnt = 0;
      bus.iFuncDone = 1'b0;
      bus.iFuncData = 8'h00;
      forever begin
         @(negedge clk);
         bus.iFuncDone = 1'b0;
         if (rst || bus.oFuncCall == 2'b00) cnt = 0;
         else if (!hang) begin
            cnt++;
            if (cnt == LAT) begin
               if (bus.oFuncCall == 2'b10) rtc[bus.oFuncAddr[3:1]] = bus.oFuncData;
               else bus.iFuncData = rtc[bus.oFuncAddr[3:1]];
               bus.iFuncDone = 1'b1;
            end
         end
      end
   end
   // Monitor: pops one expectation per call start and per tick
   initial forever begin
      @(negedge clk);
      if (rst) pc = 2'b00;
      else begin
         if (bus.oFuncCall != 2'b00 && pc == 2'b00) begin
            rise_cyc = cyc;
            ra = bus.oFuncAddr;
            if (q.size() == 0) chk("unexpected_call", {bus.oFuncCall, bus.oFuncAddr}, 0);
            else begin
               e = q.pop_front();
               chk("call_kind", 32'(e.tk), 0);
               chk("call", {bus.oFuncCall, bus.oFuncAddr, bus.oFuncData}, {e.call, e.a, e.d});
            end
         end
         if (bus.oFuncCall != 2'b00 && pc != 2'b00 && bus.oFuncCall != pc) chk("call_overlap", {pc, bus.oFuncCall}, 0);
         if (bus.oFuncCall == 2'b00 && pc != 2'b00) chk("addr_stable", pa, ra);
         if (bus.oTick) begin
            if (q.size() == 0) chk("unexpected_tick", {bus.oSec, bus.oMin, bus.oHour}, 32'hFFFF_FFFF);
            else begin
               e = q.pop_front();
               chk("tick_kind", 32'(e.tk), 1);
               chk("tick_time", {bus.oSec, bus.oMin, bus.oHour}, {e.a, e.d, e.h});
            end
         end
         pc = bus.oFuncCall;
         pa = bus.oFuncAddr;
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit, %0d compared", n_cmp);
      $fatal(1);
   end
   initial begin
      bus.iSet = 1'b0;
      bus.iTime = 24'h0;
      for (int i = 0; i < 8; i++) rtc[i] = 8'h00;
      rtc[0] = 8'h25;
      rtc[1] = 8'h07;
      rtc[2] = 8'h23;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      tx(2'b10, 8'h8E, 8'h00);
      tx(2'b01, 8'h81, 8'h00);
      tx(2'b10, 8'h8E, 8'h80);
      rst = 1'b0;
      wait_ev(0, 500, "init_ready");
      repeat (2) @(negedge clk);
      chk("init_drained", q.size(), 0);
      rtc[0] = 8'hA5;
      rst = 1'b1;
      @(negedge clk);
      chk("reset2_ready", 32'(bus.oReady), 0);
      tx(2'b10, 8'h8E, 8'h00);
      tx(2'b01, 8'h81, 8'h00);
      tx(2'b10, 8'h80, 8'h25);
      tx(2'b10, 8'h8E, 8'h80);
      rst = 1'b0;
      wait_ev(0, 500, "init_ch_ready");
      chk("ch_cleared", rtc[0], 8'h25);
      rtc[0] = 8'h59;
      poll(8'h59, 8'h07, 8'h23);
      wait_ev(1, 2500, "poll_tick");
      t1 = cyc;
      poll(8'h59, 8'h07, 8'h23);
      wait_ev(1, 2500, "poll_tick2");
      chk("poll_interval", cyc - t1, 2000);
      repeat (50) @(negedge clk);
      bus.iTime = 24'h12_34_D6;
      bus.iSet = 1'b1;
      tx(2'b10, 8'h8E, 8'h00);
      tx(2'b10, 8'h80, 8'h56);
      tx(2'b10, 8'h82, 8'h34);
      tx(2'b10, 8'h84, 8'h12);
      tx(2'b10, 8'h8E, 8'h80);
      poll(8'h56, 8'h34, 8'h12);
      wait_ev(2, 400, "set_done");
      bus.iSet = 1'b0;
      wait_ev(1, 200, "set_then_poll");
      poll(8'h56, 8'h34, 8'h12);
      wait_ev(4, 2500, "mid_poll_read83");
      bus.iTime = 24'h08_15_30;
      bus.iSet = 1'b1;
      tx(2'b10, 8'h8E, 8'h00);
      tx(2'b10, 8'h80, 8'h30);
      tx(2'b10, 8'h82, 8'h15);
      tx(2'b10, 8'h84, 8'h08);
      tx(2'b10, 8'h8E, 8'h80);
      poll(8'h30, 8'h15, 8'h08);
      wait_ev(2, 600, "set_in_poll_done");
      bus.iSet = 1'b0;
      wait_ev(1, 200, "set_in_poll_tick");
      hang = 1'b1;
      tx(2'b01, 8'h81, 8'h00);
      wait_ev(3, 2500, "timeout_err");
      chk("timeout_len", cyc - rise_cyc, TO);
      chk("timeout_call", 32'(bus.oFuncCall), 0);
      hang = 1'b0;
      poll(8'h30, 8'h15, 8'h08);
      wait_ev(1, 2500, "recover_tick");
      chk("err_sticky", 32'(bus.oErr), 1);
      hang = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      tx(2'b10, 8'h8E, 8'h00);
      rst = 1'b0;
      wait_ev(5, 10, "boot_call");
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_call_drop", 32'(bus.oFuncCall), 0);
      chk_reset("rst_mid");
      repeat (2) @(negedge clk);
      chk("all_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
